// File: rtl/msrv32_decode_stage.sv
// RV32I/M instruction decoder with a small FIFO of decoded bundles.
// Instructions are decoded on push, and the head entry drives the outputs.
module msrv32_decode_stage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned M_EXT = 0,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 ms_riscv32_mp_clk_in,
    input  logic                 ms_riscv32_mp_rst_in,
    input  logic [31:0]          instr_in,
    input  logic                 instr_valid_in,
    output logic                 instr_ready_out,
    input  logic                 trap_taken_in,
    input  logic                 flush_in,
    output logic                 dec_valid_out,
    input  logic                 dec_ready_in,
    output logic [2:0]           wb_mux_sel_out,
    output logic [2:0]           imm_type_out,
    output logic [2:0]           csr_op_out,
    output logic [4+M_EXT-1:0]   alu_opcode_out,
    output logic [1:0]           load_size_out,
    output logic                 load_unsigned_out,
    output logic                 mem_wr_req_out,
    output logic                 alu_src_out,
    output logic                 iadder_src_out,
    output logic                 csr_wr_en_out,
    output logic                 rf_wr_en_out,
    output logic                 illegal_instr_out,
    output logic [4:0]           rd_addr_out,
    output logic [4:0]           rs1_addr_out,
    output logic [4:0]           rs2_addr_out,
    output logic [CNT_W-1:0]     illegal_count_out
);

    localparam int unsigned AW = 4 + M_EXT;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] Full = (PW + 1)'(DEPTH);

    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcMisc   = 7'b0001111;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    typedef struct packed {
        logic [2:0]    wb_mux_sel;
        logic [2:0]    imm_type;
        logic [2:0]    csr_op;
        logic [AW-1:0] alu_opcode;
        logic [1:0]    load_size;
        logic          load_unsigned;
        logic          mem_wr_req;
        logic          alu_src;
        logic          iadder_src;
        logic          csr_wr_en;
        logic          rf_wr_en;
        logic          illegal_instr;
        logic [4:0]    rd_addr;
        logic [4:0]    rs1_addr;
        logic [4:0]    rs2_addr;
    } dec_t;

    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       illegal;
    dec_t       dec_d;
    dec_t       head;

    dec_t              mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       count_q;
    logic [CNT_W-1:0]  ill_cnt_q;
    logic              kill, push, pop, out_valid;

    assign rst    = ms_riscv32_mp_rst_in;
    assign opcode = instr_in[6:0];
    assign funct3 = instr_in[14:12];
    assign funct7 = instr_in[31:25];

    always_comb begin
        dec_d          = '0;
        illegal        = 1'b0;
        dec_d.rd_addr  = instr_in[11:7];
        dec_d.rs1_addr = instr_in[19:15];
        dec_d.rs2_addr = instr_in[24:20];
        case (opcode)
            OpcOp: begin
                dec_d.rf_wr_en   = 1'b1;
                dec_d.alu_opcode = AW'({funct7[5], funct3});
                if (M_EXT != 0 && funct7 == 7'b0000001) begin
                    dec_d.alu_opcode = AW'({2'b10, funct3});
                end else if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
                    illegal = 1'b1;
                end
            end
            OpcOpImm: begin
                dec_d.rf_wr_en   = 1'b1;
                dec_d.alu_src    = 1'b1;
                // Only shifts carry an arithmetic/logical select in funct7[5].
                dec_d.alu_opcode = (funct3[1:0] == 2'b01) ? AW'({funct7[5], funct3})
                                                          : AW'({1'b0, funct3});
            end
            OpcLoad: begin
                dec_d.rf_wr_en      = 1'b1;
                dec_d.wb_mux_sel    = 3'b001;
                dec_d.iadder_src    = 1'b1;
                dec_d.load_size     = funct3[1:0];
                dec_d.load_unsigned = funct3[2];
                illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OpcStore: begin
                dec_d.mem_wr_req = 1'b1;
                dec_d.imm_type   = 3'b001;
                dec_d.iadder_src = 1'b1;
                illegal = (funct3 >= 3'b011);
            end
            OpcBranch: begin
                dec_d.imm_type = 3'b010;
                illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OpcLui: begin
                dec_d.rf_wr_en   = 1'b1;
                dec_d.wb_mux_sel = 3'b010;
                dec_d.imm_type   = 3'b011;
            end
            OpcAuipc: begin
                dec_d.rf_wr_en   = 1'b1;
                dec_d.wb_mux_sel = 3'b011;
                dec_d.imm_type   = 3'b011;
            end
            OpcJal: begin
                dec_d.rf_wr_en   = 1'b1;
                dec_d.wb_mux_sel = 3'b101;
                dec_d.imm_type   = 3'b100;
            end
            OpcJalr: begin
                dec_d.rf_wr_en   = 1'b1;
                dec_d.wb_mux_sel = 3'b101;
                dec_d.iadder_src = 1'b1;
                illegal = (funct3 != 3'b000);
            end
            OpcSystem: begin
                if (funct3 != 3'b000) begin
                    dec_d.csr_wr_en  = 1'b1;
                    dec_d.csr_op     = funct3;
                    dec_d.wb_mux_sel = 3'b100;
                    dec_d.imm_type   = funct3[2] ? 3'b101 : 3'b000;
                    dec_d.rf_wr_en   = (instr_in[11:7] != 5'd0);
                end
            end
            OpcMisc: ;
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec_d.rf_wr_en   = 1'b0;
            dec_d.mem_wr_req = 1'b0;
            dec_d.csr_wr_en  = 1'b0;
        end
        dec_d.illegal_instr = illegal;
    end

    assign kill            = trap_taken_in | flush_in;
    assign instr_ready_out = !rst && (count_q != Full);
    assign out_valid       = !rst && (count_q != '0);
    assign push            = instr_valid_in && instr_ready_out && !kill;
    assign pop             = out_valid && dec_ready_in && !kill;

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ill_cnt_q <= '0;
        end else if (kill) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + (PW + 1)'(1);
            else if (pop && !push) count_q <= count_q - (PW + 1)'(1);
            if (push && dec_d.illegal_instr && (ill_cnt_q != '1)) begin
                ill_cnt_q <= ill_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (push) mem_q[wr_ptr_q] <= dec_d;
    end

    assign head              = out_valid ? mem_q[rd_ptr_q] : '0;
    assign dec_valid_out     = out_valid;
    assign wb_mux_sel_out    = head.wb_mux_sel;
    assign imm_type_out      = head.imm_type;
    assign csr_op_out        = head.csr_op;
    assign alu_opcode_out    = head.alu_opcode;
    assign load_size_out     = head.load_size;
    assign load_unsigned_out = head.load_unsigned;
    assign mem_wr_req_out    = head.mem_wr_req;
    assign alu_src_out       = head.alu_src;
    assign iadder_src_out    = head.iadder_src;
    assign csr_wr_en_out     = head.csr_wr_en;
    assign rf_wr_en_out      = head.rf_wr_en;
    assign illegal_instr_out = head.illegal_instr;
    assign rd_addr_out       = head.rd_addr;
    assign rs1_addr_out      = head.rs1_addr;
    assign rs2_addr_out      = head.rs2_addr;
    assign illegal_count_out = rst ? '0 : ill_cnt_q;

endmodule

// File: tb/tb_msrv32_decode_stage.sv
// Scoreboard bench for msrv32_decode_stage: a reference decoder fills an expected
// queue on every accepted push; the head is compared every cycle.
module tb_msrv32_decode_stage;

    localparam int DEPTH = 2;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [2:0] wb, imm, csr;
        logic [4:0] alu;
        logic [1:0] lsz;
        logic       lun, mw, asrc, isrc, cwe, rwe, ill;
        logic [4:0] rd, rs1, rs2;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, v0 = 1'b0, rdy0 = 1'b0, trap = 1'b0, flush = 1'b0;
    logic [31:0] i0 = '0;
    logic        o_ready, o_valid, o_lun, o_mw, o_asrc, o_isrc, o_cwe, o_rwe, o_ill;
    logic [2:0]  o_wb, o_imm, o_csr;
    logic [3:0]  o_alu;
    logic [1:0]  o_lsz;
    logic [4:0]  o_rd, o_rs1, o_rs2;
    logic [7:0]  o_cnt;

    logic        v1 = 1'b0, rdy1 = 1'b1, zero1 = 1'b0;
    logic [31:0] i1 = '0;
    logic        p_ready, p_valid, p_lun, p_mw, p_asrc, p_isrc, p_cwe, p_rwe, p_ill;
    logic [2:0]  p_wb, p_imm, p_csr;
    logic [4:0]  p_alu;
    logic [1:0]  p_lsz;
    logic [4:0]  p_rd, p_rs1, p_rs2;
    logic [7:0]  p_cnt;

    msrv32_decode_stage #(.DEPTH(DEPTH), .M_EXT(0), .CNT_W(CNT_W)) u_dut (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
        .instr_in(i0), .instr_valid_in(v0), .instr_ready_out(o_ready),
        .trap_taken_in(trap), .flush_in(flush),
        .dec_valid_out(o_valid), .dec_ready_in(rdy0),
        .wb_mux_sel_out(o_wb), .imm_type_out(o_imm), .csr_op_out(o_csr),
        .alu_opcode_out(o_alu), .load_size_out(o_lsz), .load_unsigned_out(o_lun),
        .mem_wr_req_out(o_mw), .alu_src_out(o_asrc), .iadder_src_out(o_isrc),
        .csr_wr_en_out(o_cwe), .rf_wr_en_out(o_rwe), .illegal_instr_out(o_ill),
        .rd_addr_out(o_rd), .rs1_addr_out(o_rs1), .rs2_addr_out(o_rs2),
        .illegal_count_out(o_cnt)
    );

    msrv32_decode_stage #(.DEPTH(DEPTH), .M_EXT(1), .CNT_W(CNT_W)) u_dut_m (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
        .instr_in(i1), .instr_valid_in(v1), .instr_ready_out(p_ready),
        .trap_taken_in(zero1), .flush_in(zero1),
        .dec_valid_out(p_valid), .dec_ready_in(rdy1),
        .wb_mux_sel_out(p_wb), .imm_type_out(p_imm), .csr_op_out(p_csr),
        .alu_opcode_out(p_alu), .load_size_out(p_lsz), .load_unsigned_out(p_lun),
        .mem_wr_req_out(p_mw), .alu_src_out(p_asrc), .iadder_src_out(p_isrc),
        .csr_wr_en_out(p_cwe), .rf_wr_en_out(p_rwe), .illegal_instr_out(p_ill),
        .rd_addr_out(p_rd), .rs1_addr_out(p_rs1), .rs2_addr_out(p_rs2),
        .illegal_count_out(p_cnt)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cnt_m   = 0;
    exp_t sbq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model_dec(input logic [31:0] ins, input bit mext);
        exp_t       e;
        logic [2:0] f3;
        logic [6:0] f7;
        e   = '0;
        f3  = ins[14:12];
        f7  = ins[31:25];
        e.rd  = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        case (ins[6:0])
            7'h33: begin
                e.rwe = 1;
                e.alu = {1'b0, f7[5], f3};
                if (mext && f7 == 7'h01) e.alu = {2'b10, f3};
                else if (f7 != 7'h00 && f7 != 7'h20) e.ill = 1;
            end
            7'h13: begin
                e.rwe = 1; e.asrc = 1;
                e.alu = (f3 == 3'd1 || f3 == 3'd5) ? {1'b0, f7[5], f3} : {2'b00, f3};
            end
            7'h03: begin
                e.rwe = 1; e.wb = 3'd1; e.isrc = 1; e.lsz = f3[1:0]; e.lun = f3[2];
                if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) e.ill = 1;
            end
            7'h23: begin
                e.mw = 1; e.imm = 3'd1; e.isrc = 1;
                if (f3 > 3'd2) e.ill = 1;
            end
            7'h63: begin
                e.imm = 3'd2;
                if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1;
            end
            7'h37: begin e.rwe = 1; e.wb = 3'd2; e.imm = 3'd3; end
            7'h17: begin e.rwe = 1; e.wb = 3'd3; e.imm = 3'd3; end
            7'h6F: begin e.rwe = 1; e.wb = 3'd5; e.imm = 3'd4; end
            7'h67: begin
                e.rwe = 1; e.wb = 3'd5; e.isrc = 1;
                if (f3 != 3'd0) e.ill = 1;
            end
            7'h0F: ;
            7'h73: begin
                if (f3 != 3'd0) begin
                    e.cwe = 1; e.csr = f3; e.wb = 3'd4;
                    e.imm = f3[2] ? 3'd5 : 3'd0;
                    e.rwe = (ins[11:7] != 5'd0);
                end
            end
            default: e.ill = 1;
        endcase
        if (e.ill) begin e.rwe = 0; e.mw = 0; e.cwe = 0; end
        return e;
    endfunction

    // Compares the current head against the scoreboard, then advances one clock.
    task automatic tick();
        exp_t e;
        int   sz;
        bit   ev, er, dp, dpop, kill;
        #1;
        sz   = sbq.size();
        kill = trap || flush;
        ev   = !rst && sz > 0;
        er   = !rst && sz < DEPTH;
        e    = ev ? sbq[0] : '0;
        check_eq("dec_valid", o_valid, ev);
        check_eq("instr_ready", o_ready, er);
        check_eq("illegal_count", o_cnt, rst ? 0 : cnt_m);
        check_eq("wb_mux_sel", o_wb, e.wb);
        check_eq("imm_type", o_imm, e.imm);
        check_eq("csr_op", o_csr, e.csr);
        check_eq("alu_opcode", o_alu, e.alu);
        check_eq("load_size", o_lsz, e.lsz);
        check_eq("load_unsigned", o_lun, e.lun);
        check_eq("mem_wr_req", o_mw, e.mw);
        check_eq("alu_src", o_asrc, e.asrc);
        check_eq("iadder_src", o_isrc, e.isrc);
        check_eq("csr_wr_en", o_cwe, e.cwe);
        check_eq("rf_wr_en", o_rwe, e.rwe);
        check_eq("illegal_instr", o_ill, e.ill);
        check_eq("rd_addr", o_rd, e.rd);
        check_eq("rs1_addr", o_rs1, e.rs1);
        check_eq("rs2_addr", o_rs2, e.rs2);
        dp   = !rst && !kill && v0 && sz < DEPTH;
        dpop = !rst && !kill && ev && rdy0;
        @(posedge clk);
        #1;
        if (rst) begin
            sbq.delete();
            cnt_m = 0;
        end else if (kill) begin
            sbq.delete();
        end else begin
            if (dpop) void'(sbq.pop_front());
            if (dp) begin
                e = model_dec(i0, 1'b0);
                sbq.push_back(e);
                if (e.ill && cnt_m < CMAX) cnt_m++;
            end
        end
    endtask

    logic [31:0] tbl [22] = '{
        32'h002081B3, 32'h40415093, 32'h022081B3, 32'h402081B3, 32'h0080A283,
        32'h0040C283, 32'h0020A623, 32'h00208463, 32'h008000EF, 32'h000100E7,
        32'h123452B7, 32'h00001297, 32'h300110F3, 32'h30036073, 32'h0FF0000F,
        32'h00000073, 32'h0000B283, 32'h0020B623, 32'h0020A463, 32'h000110E7,
        32'h202081B3, 32'h00309093
    };

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // add x3,x1,x2 on the base decoder; mul on the M-extension decoder
        v0 = 1; i0 = 32'h002081B3; v1 = 1; i1 = 32'h022081B3;
        tick();
        v0 = 0; v1 = 0;
        check_eq("add_valid", o_valid, 1);
        check_eq("add_alu", o_alu, 4'b0000);
        check_eq("add_wb", o_wb, 3'b000);
        check_eq("add_rwe", o_rwe, 1);
        check_eq("add_rd", o_rd, 3);
        check_eq("add_rs1", o_rs1, 1);
        check_eq("add_rs2", o_rs2, 2);
        check_eq("mext_mul_valid", p_valid, 1);
        check_eq("mext_mul_alu", p_alu, 5'b10000);
        check_eq("mext_mul_ill", p_ill, 0);
        rdy0 = 1;
        tick();
        check_eq("mext_popped", p_valid, 0);
        rdy0 = 0;

        // srai x1,x2,4; sub on the M-extension decoder
        v0 = 1; i0 = 32'h40415093; v1 = 1; i1 = 32'h402081B3;
        tick();
        v0 = 0; v1 = 0;
        check_eq("srai_alu", o_alu, 4'b1101);
        check_eq("srai_asrc", o_asrc, 1);
        check_eq("srai_imm", o_imm, 3'b000);
        check_eq("mext_sub_alu", p_alu, 5'b01000);
        rdy0 = 1;
        tick();
        rdy0 = 0;

        // Fill with consumer stalled, then push while full
        v0 = 1; i0 = 32'h0080A283;
        tick();
        i0 = 32'h0020A623;
        tick();
        check_eq("full_ready", o_ready, 0);
        i0 = 32'h123452B7;
        tick();
        v0 = 0; rdy0 = 1;
        tick();
        check_eq("ready_after_pop", o_ready, 1);
        rdy0 = 0;
        tick();
        rdy0 = 1;
        repeat (2) tick();

        // Illegal instruction and count saturation
        v0 = 1; i0 = 32'h00000000;
        tick();
        v0 = 0;
        check_eq("zero_ill", o_ill, 1);
        check_eq("zero_rwe", o_rwe, 0);
        check_eq("zero_count", o_cnt, 1);
        tick();
        v0 = 1;
        for (int k = 0; k < 300; k++) begin
            i0 = (k % 2 == 0) ? 32'h00000000 : 32'h022081B3;
            tick();
        end
        v0 = 0;
        repeat (2) tick();
        check_eq("count_saturated", o_cnt, CMAX);

        // Trap alongside a push
        rdy0 = 0; v0 = 1; i0 = 32'h00001297;
        repeat (2) tick();
        i0 = 32'h008000EF; trap = 1;
        tick();
        trap = 0; v0 = 0;
        check_eq("trap_valid", o_valid, 0);
        check_eq("trap_ready", o_ready, 1);
        repeat (2) tick();

        // Flush alongside a push and a would-be pop
        v0 = 1; i0 = 32'h300110F3;
        repeat (2) tick();
        i0 = 32'h00309093; flush = 1; rdy0 = 1;
        tick();
        flush = 0; v0 = 0;
        check_eq("flush_valid", o_valid, 0);
        repeat (2) tick();

        // Reset mid-stream
        rdy0 = 0; v0 = 1; i0 = 32'h30036073;
        repeat (2) tick();
        v0 = 0; rst = 1;
        repeat (2) tick();
        rst = 0;
        tick();

        // Random mix under random backpressure and occasional flush
        for (int k = 0; k < 400; k++) begin
            v0    = 1'($urandom_range(0, 1));
            i0    = tbl[$urandom_range(0, 21)];
            rdy0  = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 15) == 0);
            tick();
        end
        flush = 0; v0 = 0; rdy0 = 1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
